// File: rtl/wb_sram_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the SRAM controller slave.
// Whole bus cycles are granted; a per-strobe wait-state timeout forces an error.
module wb_sram_arbiter #(
  parameter int ADDR_WIDTH     = 24,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_adr_i,
  input  logic [7:0]            m0_dat_i,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  output logic                  m0_rty_o,
  output logic [7:0]            m0_dat_o,
  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_adr_i,
  input  logic [7:0]            m1_dat_i,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic                  m1_rty_o,
  output logic [7:0]            m1_dat_o,
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [ADDR_WIDTH-1:0] s_adr_o,
  output logic [7:0]            s_dat_o,
  input  logic                  s_ack_i,
  input  logic                  s_err_i,
  input  logic                  s_rty_i,
  input  logic [7:0]            s_dat_i,
  output logic [1:0]            grant_o,
  output logic                  timeout_o
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

  state_t          r_state, w_state_d;
  logic            r_last, w_last_d;
  logic [CW-1:0]   r_cnt;
  logic            w_term, w_force;

  assign w_term  = s_ack_i | s_err_i | s_rty_i;
  // A slave termination in the limit cycle takes precedence over the forced error.
  assign w_force = (TIMEOUT_CYCLES != 0) && (r_cnt == CW'(TIMEOUT_CYCLES)) &&
                   (r_state != IDLE) && !w_term;

  assign m0_dat_o  = s_dat_i;
  assign m1_dat_o  = s_dat_i;
  assign grant_o   = {r_state == GNT1, r_state == GNT0};
  assign timeout_o = w_force;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_d;
      r_last  <= w_last_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_last_d  = r_last;
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_adr_o   = '0;
    s_dat_o   = '0;
    m0_ack_o  = 1'b0;
    m0_err_o  = 1'b0;
    m0_rty_o  = 1'b0;
    m1_ack_o  = 1'b0;
    m1_err_o  = 1'b0;
    m1_rty_o  = 1'b0;
    case (r_state)
      IDLE: begin
        if (m0_cyc_i && (!m1_cyc_i || r_last)) begin
          w_state_d = GNT0;
          w_last_d  = 1'b0;
        end else if (m1_cyc_i) begin
          w_state_d = GNT1;
          w_last_d  = 1'b1;
        end
      end
      GNT0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i & ~w_force;
        s_we_o   = m0_we_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        m0_ack_o = s_ack_i & ~w_force;
        m0_err_o = (s_err_i & ~w_force) | w_force;
        m0_rty_o = s_rty_i & ~w_force;
        if (!m0_cyc_i) w_state_d = IDLE;
      end
      GNT1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i & ~w_force;
        s_we_o   = m1_we_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        m1_ack_o = s_ack_i & ~w_force;
        m1_err_o = (s_err_i & ~w_force) | w_force;
        m1_rty_o = s_rty_i & ~w_force;
        if (!m1_cyc_i) w_state_d = IDLE;
      end
      default: w_state_d = IDLE;
    endcase
  end

  // Counts unterminated strobe cycles; any grant change restarts the window.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      r_cnt <= '0;
    else if ((w_state_d != r_state) || w_term || w_force)
      r_cnt <= '0;
    else if (s_stb_o)
      r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: tb/tb_wb_sram_arbiter.sv
// Bench for wb_sram_arbiter: directed scenarios plus random traffic, all cycles
// checked against a bus-ownership model of the arbiter.
module tb_wb_sram_arbiter;
  localparam int AW = 24;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mcyc[2], mstb[2], mwe[2];
  logic [AW-1:0] madr[2];
  logic [7:0]    mdat[2];
  logic          sack, serr, srty;
  logic [7:0]    sdat;

  logic          m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty;
  logic [7:0]    m0_dato, m1_dato, s_dato;
  logic          s_cyc, s_stb, s_we, tmo;
  logic [AW-1:0] s_adr;
  logic [1:0]    gnt;

  int n_chk = 0;
  int n_err = 0;

  // model: owner 0 = none, 1 = M0, 2 = M1; prev = index of last granted master
  int owner, prev, age;

  wb_sram_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_cyc_i(mcyc[0]), .m0_stb_i(mstb[0]), .m0_we_i(mwe[0]), .m0_adr_i(madr[0]),
    .m0_dat_i(mdat[0]), .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_rty_o(m0_rty),
    .m0_dat_o(m0_dato),
    .m1_cyc_i(mcyc[1]), .m1_stb_i(mstb[1]), .m1_we_i(mwe[1]), .m1_adr_i(madr[1]),
    .m1_dat_i(mdat[1]), .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_rty_o(m1_rty),
    .m1_dat_o(m1_dato),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr), .s_dat_o(s_dato),
    .s_ack_i(sack), .s_err_i(serr), .s_rty_i(srty), .s_dat_i(sdat),
    .grant_o(gnt), .timeout_o(tmo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit forced();
    return (owner != 0) && (age == TO) && !(sack || serr || srty);
  endfunction

  task automatic model_reset();
    owner = 0; prev = 1; age = 0;
  endtask

  task automatic check_outputs();
    int  n;
    bit  f, on;
    f  = forced();
    on = (owner != 0);
    n  = on ? owner - 1 : 0;
    chk("s_cyc", s_cyc, on && mcyc[n]);
    chk("s_stb", s_stb, on && mstb[n] && !f);
    chk("s_we",  s_we,  on && mwe[n]);
    chk("s_adr", s_adr, on ? madr[n] : 0);
    chk("s_dat", s_dato, on ? mdat[n] : 0);
    chk("m0_ack", m0_ack, owner == 1 && sack && !f);
    chk("m0_err", m0_err, owner == 1 && (f || serr));
    chk("m0_rty", m0_rty, owner == 1 && srty && !f);
    chk("m1_ack", m1_ack, owner == 2 && sack && !f);
    chk("m1_err", m1_err, owner == 2 && (f || serr));
    chk("m1_rty", m1_rty, owner == 2 && srty && !f);
    chk("m0_dat", m0_dato, sdat);
    chk("m1_dat", m1_dato, sdat);
    chk("grant", gnt, owner == 1 ? 2'b01 : owner == 2 ? 2'b10 : 2'b00);
    chk("timeout", tmo, f);
  endtask

  task automatic model_step();
    bit f;
    f = forced();
    if (owner == 0) begin
      if (mcyc[0] && mcyc[1]) owner = (prev == 1) ? 1 : 2;
      else if (mcyc[0])       owner = 1;
      else if (mcyc[1])       owner = 2;
      if (owner != 0) begin prev = owner - 1; age = 0; end
    end else if (!mcyc[owner-1]) begin
      owner = 0; age = 0;
    end else if (sack || serr || srty || f) begin
      age = 0;
    end else if (mstb[owner-1]) begin
      age++;
    end
  endtask

  // called at a negedge with inputs set; returns at the following negedge
  task automatic tick();
    #1 check_outputs();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    for (int k = 0; k < 2; k++) begin
      mcyc[k] = 0; mstb[k] = 0; mwe[k] = 0; madr[k] = '0; mdat[k] = '0;
    end
    sack = 0; serr = 0; srty = 0; sdat = 8'h00;
  endtask

  initial begin
    int w;
    int g;
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1 check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // tie right after reset: M0 first, one idle cycle, then M1
    mcyc[0] = 1; mstb[0] = 1; mcyc[1] = 1; mstb[1] = 1; sack = 1; sdat = 8'h5a;
    madr[0] = 24'h000010; madr[1] = 24'h000020;
    tick();
    #1 chk("tie_first", gnt, 2'b01);
    tick();
    mcyc[0] = 0; mstb[0] = 0;
    tick();
    #1 chk("tie_idle", gnt, 2'b00);
    tick();
    #1 chk("tie_second", gnt, 2'b10);
    mcyc[1] = 0; mstb[1] = 0;
    tick();

    // M1 reads 0x400..0x402 with the slave acking every cycle
    mcyc[1] = 1; mstb[1] = 1; madr[1] = 24'h000400; sack = 1;
    tick();
    for (int a = 0; a < 3; a++) begin
      madr[1] = 24'h000400 + AW'(a);
      sdat = 8'h30 + 8'(a);
      #1 chk("rd_adr", s_adr, 24'h000400 + a);
      chk("rd_m1ack", m1_ack, 1);
      chk("rd_m0ack", m0_ack, 0);
      tick();
    end
    mcyc[1] = 0; mstb[1] = 0;
    tick();

    // continuous requests from both: grants must alternate
    for (int k = 0; k < 2; k++) begin mcyc[k] = 1; mstb[k] = 1; end
    sack = 1;
    for (int t = 0; t < 8; t++) begin
      w = 0;
      while (gnt == 2'b00 && w < 5) begin tick(); w++; end
      g = t % 2;
      chk("rr_grant", gnt, (g == 0) ? 2'b01 : 2'b10);
      tick();
      mcyc[g] = 0; mstb[g] = 0;
      tick();
      mcyc[g] = 1; mstb[g] = 1;
    end
    idle_inputs();
    tick();
    tick();

    // slave never acks M1: forced error on the 5th strobe cycle, then again
    mcyc[1] = 1; mstb[1] = 1; madr[1] = 24'h00beef;
    tick();
    for (int r = 0; r < 2; r++) begin
      for (int i = 1; i <= TO + 1; i++) begin
        #1 chk("to_pulse", tmo, i == TO + 1);
        chk("to_stb", s_stb, i != TO + 1);
        chk("to_err", m1_err, i == TO + 1);
        tick();
      end
    end
    // slave acks exactly in the limit cycle: ack wins
    for (int i = 1; i <= TO + 1; i++) begin
      sack = (i == TO + 1);
      #1 chk("late_ack", m1_ack, i == TO + 1);
      chk("late_to", tmo, 0);
      tick();
    end
    idle_inputs();
    tick();

    // async reset in the middle of an M0 grant
    mcyc[0] = 1; mstb[0] = 1; sack = 1; madr[0] = 24'h000777;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1 chk("rst_cyc", s_cyc, 0);
    chk("rst_stb", s_stb, 0);
    chk("rst_grant", gnt, 0);
    chk("rst_ack", m0_ack, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    mcyc[1] = 1; mstb[1] = 1;
    tick();
    #1 chk("rst_tie", gnt, 2'b01);
    idle_inputs();
    tick();
    tick();

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (mcyc[k]) mcyc[k] = ($urandom_range(0, 7) != 0);
        else         mcyc[k] = ($urandom_range(0, 3) == 0);
        mstb[k] = mcyc[k] && ($urandom_range(0, 3) != 0);
        mwe[k]  = 1'($urandom_range(0, 1));
        madr[k] = AW'($urandom);
        mdat[k] = 8'($urandom);
      end
      sack = ($urandom_range(0, 3) == 0);
      serr = ($urandom_range(0, 15) == 0);
      srty = ($urandom_range(0, 15) == 0);
      sdat = 8'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
